md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  E-stage multiply/divide unit with architectural HI/LO registers.
//  Executes mult/multu/div/divu over several cycles and mthi/mtlo in one.
//  busy feeds the hazard unit; hi/lo feed the E-stage ALU-out mux for mfhi/mflo,
//  and that mux's output becomes AO_M.
//  flush is the M-stage exception/interrupt request. It cancels an md instruction
//  that is in E in the same cycle.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1; unused when MD_ITERATIVE_DIV_EN)
// PORTS
//  clk    in   1   clock, rising edge
//  reset  in   1   synchronous, active-high
//  start  in   1   E-stage instr is an md op (qualified by op)
//  op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//  a      in   32  forwarded rs
//  b      in   32  forwarded rt
//  flush  in   1   exception/interrupt taken this cycle
//  busy   out  1   operation in flight (registered)
//  hi     out  32  architectural HI (registered)
//  lo     out  32  architectural LO (registered)
// BEHAVIOUR
//  - Reset: busy=0, hi=0, lo=0, counter=0, shadow result=0; any op in flight is discarded.
//  - Accept: the op is accepted on edge T when start & ~flush & ~busy & op<=5.
//    start while busy is ignored; the hazard unit guarantees it does not occur.
//  - flush & start on the same edge: nothing accepted, no state change.
//  - flush while busy: no effect; the in-flight op completes.
//  - mthi/mtlo: hi<=a or lo<=a at edge T; busy stays 0.
//  - mult/div: operands latched at edge T. busy=1 for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES).
//    hi/lo are written on the edge where busy falls, so the new values are visible
//    in the first cycle with busy=0.
//  - Counter: loaded with N at T, decremented each edge; at value 1 it commits and goes to 0.
//  - mult: {hi,lo} = $signed(a)*$signed(b), 64-bit. multu: unsigned 64-bit product.
//  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//  - divu: unsigned quotient and remainder.
//  - Divide by zero (b==0): full busy period runs; hi/lo are left unchanged on commit.
//  - hi/lo hold between operations; mid-operation reads return the old values.
// CONFIGURATION
//  MD_ITERATIVE_DIV_EN defined:
//    - div/divu use a radix-2 restoring shift-subtract datapath on operand magnitudes.
//    - 32 iteration cycles plus 1 sign-fix cycle, so busy=1 for 33 cycles; DIV_CYCLES is ignored.
//    - Results must equal the non-iterative definitions above, including the b==0 and overflow cases.
//  Undefined:
//    - div/divu computed with / and %, held in the shadow register for DIV_CYCLES; no iterative logic.
// TESTING
//  - Reset, then mult a=0xFFFFFFFE b=3 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 in the first cycle busy=0.
//  - div a=-7 (0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    Busy cycles: 10, or 33 with MD_ITERATIVE_DIV_EN.
//  - mthi a=0x12345678 with flush=1 -> hi unchanged.
//    Next cycle with flush=0 -> hi=0x12345678, busy stays 0.
//  - divu a=100 b=0 after hi=1, lo=2 -> busy full period, then hi=1, lo=2.
//  - Start mult, assert reset on the 3rd busy cycle -> next cycle busy=0, hi=0, lo=0;
//    no later commit occurs.

Source files
------------

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding the architectural HI/LO registers.
// Define MD_ITERATIVE_DIV_EN to replace the single-shot divider with a 33-cycle radix-2 restoring divider.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_ITERATIVE_DIV_EN
   localparam int unsigned DIV_N = 33;
`else
   localparam int unsigned DIV_N = DIV_CYCLES;
`endif
   localparam int unsigned MAX_N = (MULT_CYCLES > DIV_N) ? MULT_CYCLES : DIV_N;
   localparam int unsigned CNT_W = $clog2(MAX_N + 1);

   logic             busy_q, busy_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      shadow_q, shadow_d;
   logic             dz_q, dz_d;
   logic             accept;
   logic [63:0]      prod_s, prod_u;

   assign accept = start & ~flush & ~busy_q & (op <= OP_MTLO);
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MD_ITERATIVE_DIV_EN
   logic        is_div_q, is_div_d, negq_q, negq_d, negr_q, negr_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] shifted, diff;

   assign a_neg   = (op == OP_DIV) & a[31];
   assign b_neg   = (op == OP_DIV) & b[31];
   assign a_mag   = a_neg ? -a : a;
   assign b_mag   = b_neg ? -b : b;
   // Partial remainder stays below the divisor, so bit 32 of diff is a clean borrow flag.
   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {1'b0, dvs_q};
`else
   logic [31:0] div_q, div_r;

   always_comb begin
      div_q = '0;
      div_r = '0;
      if (b != 32'd0) begin
         if (op == OP_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               div_q = a;
            end else begin
               div_q = $signed(a) / $signed(b);
               div_r = $signed(a) % $signed(b);
            end
         end else begin
            div_q = a / b;
            div_r = a % b;
         end
      end
   end
`endif

   always_comb begin
      // NOTE: every next-state signal takes its held value first so no path infers a latch.
      busy_d   = busy_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      dz_d     = dz_q;
`ifdef MD_ITERATIVE_DIV_EN
      is_div_d = is_div_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
`endif
      if (accept) begin
         case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU: begin
               shadow_d = (op == OP_MULT) ? prod_s : prod_u;
               dz_d     = 1'b0;
               cnt_d    = CNT_W'(MULT_CYCLES);
               busy_d   = 1'b1;
`ifdef MD_ITERATIVE_DIV_EN
               is_div_d = 1'b0;
`endif
            end
            default: begin
               dz_d   = (b == 32'd0);
               cnt_d  = CNT_W'(DIV_N);
               busy_d = 1'b1;
`ifdef MD_ITERATIVE_DIV_EN
               is_div_d = 1'b1;
               rem_d    = '0;
               quo_d    = a_mag;
               dvs_d    = b_mag;
               negq_d   = a_neg ^ b_neg;
               negr_d   = a_neg;
`else
               shadow_d = {div_r, div_q};
`endif
            end
         endcase
      end else if (busy_q) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            if (!dz_q) begin
`ifdef MD_ITERATIVE_DIV_EN
               if (is_div_q) begin
                  hi_d = negr_q ? -rem_q : rem_q;
                  lo_d = negq_q ? -quo_q : quo_q;
               end else begin
                  {hi_d, lo_d} = shadow_q;
               end
`else
               {hi_d, lo_d} = shadow_q;
`endif
            end
`ifdef MD_ITERATIVE_DIV_EN
         end else if (is_div_q) begin
            rem_d = diff[32] ? shifted[31:0] : diff[31:0];
            quo_d = {quo_q[30:0], ~diff[32]};
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignment; the shadow result is reset too so a cancelled op leaves nothing behind.
      if (reset) begin
         busy_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         dz_q     <= 1'b0;
`ifdef MD_ITERATIVE_DIV_EN
         is_div_q <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
`endif
      end else begin
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         dz_q     <= dz_d;
`ifdef MD_ITERATIVE_DIV_EN
         is_div_q <= is_div_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
`endif
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of directed ops plus hand sequences for flush and reset corners.
// Honours MD_ITERATIVE_DIV_EN for the expected divide busy length.
module tb_md_unit;
   localparam int MULT_N = 5;
`ifdef MD_ITERATIVE_DIV_EN
   localparam int DIV_N = 33;
`else
   localparam int DIV_N = 10;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd6;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // Issues one op for a single cycle, then counts busy cycles and samples hi/lo in the first busy cycle.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic fl, output int cyc, output logic [31:0] mh, output logic [31:0] ml);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; flush = fl;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0; op = 3'd6;
      cyc = 0; mh = hi; ml = lo;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         if (cyc == 0) begin
            mh = hi;
            ml = lo;
         end
         cyc++;
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] mh, ml, prev_hi, prev_lo;

      vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N,  32'h0000_0000, 32'h8000_0000};
      vecs[4]  = '{3'd3, 32'd100,       32'd7,         DIV_N,  32'h0000_0002, 32'h0000_000E};
      vecs[5]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, DIV_N,  32'h0000_0001, 32'hFFFF_FFFD};
      vecs[6]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, MULT_N, 32'h4000_0000, 32'h0000_0000};
      vecs[7]  = '{3'd3, 32'hFFFF_FFFF, 32'd10,        DIV_N,  32'h0000_0005, 32'h1999_9999};
      vecs[8]  = '{3'd4, 32'hDEAD_BEEF, 32'h0,         0,      32'hDEAD_BEEF, 32'h1999_9999};
      vecs[9]  = '{3'd5, 32'h0BAD_F00D, 32'h0,         0,      32'hDEAD_BEEF, 32'h0BAD_F00D};
      vecs[10] = '{3'd2, 32'hFFFF_FFF8, 32'h0,         DIV_N,  32'hDEAD_BEEF, 32'h0BAD_F00D};
      vecs[11] = '{3'd6, 32'h1111_1111, 32'h2222_2222, 0,      32'hDEAD_BEEF, 32'h0BAD_F00D};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);

      prev_hi = 32'd0;
      prev_lo = 32'd0;
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc, mh, ml);
         check($sformatf("vec%0d busy cycles", i), cyc, vecs[i].cyc);
         check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
         if (vecs[i].cyc > 0) begin
            check($sformatf("vec%0d mid hi", i), mh, prev_hi);
            check($sformatf("vec%0d mid lo", i), ml, prev_lo);
         end
         prev_hi = vecs[i].hi;
         prev_lo = vecs[i].lo;
      end

      // mthi blocked by flush, then accepted on retry.
      run_op(3'd4, 32'h1234_5678, 32'h0, 1'b1, cyc, mh, ml);
      check("mthi flushed hi", hi, 32'hDEAD_BEEF);
      check("mthi flushed busy", cyc, 0);
      run_op(3'd4, 32'h1234_5678, 32'h0, 1'b0, cyc, mh, ml);
      check("mthi hi", hi, 32'h1234_5678);
      check("mthi busy", cyc, 0);

      // divu by zero after hi=1, lo=2 leaves both intact.
      run_op(3'd4, 32'd1, 32'h0, 1'b0, cyc, mh, ml);
      run_op(3'd5, 32'd2, 32'h0, 1'b0, cyc, mh, ml);
      run_op(3'd3, 32'd100, 32'd0, 1'b0, cyc, mh, ml);
      check("divu0 busy cycles", cyc, DIV_N);
      check("divu0 hi", hi, 32'd1);
      check("divu0 lo", lo, 32'd2);

      // flush raised during the busy period must not disturb the op.
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd6; flush = 1'b1;
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
      end
      flush = 1'b0;
      check("flush-busy cycles", cyc, MULT_N);
      check("flush-busy hi", hi, 32'd0);
      check("flush-busy lo", lo, 32'd15);

      // start together with flush accepts nothing.
      run_op(3'd0, 32'd2, 32'd2, 1'b1, cyc, mh, ml);
      check("start+flush busy", cyc, 0);
      repeat (MULT_N + 1) @(negedge clk);
      check("start+flush lo", lo, 32'd15);

      // reset in the third busy cycle discards the op.
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd6;
      repeat (3) @(negedge clk);
      check("pre-reset busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid-reset busy", {31'd0, busy}, 32'd0);
      check("mid-reset hi", hi, 32'd0);
      check("mid-reset lo", lo, 32'd0);
      reset = 1'b0;
      repeat (MULT_N + 5) @(negedge clk);
      check("post-reset busy", {31'd0, busy}, 32'd0);
      check("post-reset hi", hi, 32'd0);
      check("post-reset lo", lo, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
